// File: rtl/mips_mc_control_fsm.sv
// Multi-cycle MIPS main control: Moore FSM stepped by en, driving datapath selects and strobes.
// Define MIPS_JAL_EN to add the jal instruction (opcode 000011) via the JAL state.
module mips_mc_control_fsm #(
    parameter int OPC_W = 6,
    parameter int ST_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output logic             pc_en,
    output logic             ior_d,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             illegal,
    output logic [ST_W-1:0]  state
);

    localparam logic [ST_W-1:0] FETCH  = ST_W'(0);
    localparam logic [ST_W-1:0] DECODE = ST_W'(1);
    localparam logic [ST_W-1:0] MEMADR = ST_W'(2);
    localparam logic [ST_W-1:0] MEMRD  = ST_W'(3);
    localparam logic [ST_W-1:0] MEMWB  = ST_W'(4);
    localparam logic [ST_W-1:0] MEMWR  = ST_W'(5);
    localparam logic [ST_W-1:0] EXEC   = ST_W'(6);
    localparam logic [ST_W-1:0] ALUWB  = ST_W'(7);
    localparam logic [ST_W-1:0] BRANCH = ST_W'(8);
    localparam logic [ST_W-1:0] ADDIEX = ST_W'(9);
    localparam logic [ST_W-1:0] ADDIWB = ST_W'(10);
    localparam logic [ST_W-1:0] JUMP   = ST_W'(11);
    localparam logic [ST_W-1:0] JAL    = ST_W'(12);

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);
    localparam logic [OPC_W-1:0] OP_JAL   = OPC_W'(6'b000011);

    logic [ST_W-1:0] next_state;
    logic            bad_op;
    logic            ir_write_raw;
    logic            mem_write_raw;
    logic            reg_write_raw;
    logic            pc_write;
    logic            branch;
    logic            go;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            illegal <= 1'b0;
        end else if (en) begin
            state <= next_state;
            if (bad_op)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        next_state = FETCH;
        bad_op     = 1'b0;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXEC;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
`ifdef MIPS_JAL_EN
                    OP_JAL:       next_state = JAL;
`endif
                    default: begin
                        next_state = FETCH;
                        bad_op     = 1'b1;
                    end
                endcase
            end
            MEMADR: next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  next_state = MEMWB;
            EXEC:   next_state = ALUWB;
            ADDIEX: next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        ior_d         = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'b00;
        pc_src        = 2'd0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b    = 2'd1;
                ir_write_raw = 1'b1;
                pc_write     = 1'b1;
            end
            DECODE: alu_src_b = 2'd3;
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            MEMRD: ior_d = 1'b1;
            MEMWB: begin
                mem_to_reg    = 2'd1;
                reg_write_raw = 1'b1;
            end
            MEMWR: begin
                ior_d         = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_dst       = 2'd1;
                reg_write_raw = 1'b1;
            end
            ADDIWB: reg_write_raw = 1'b1;
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'd1;
                branch    = 1'b1;
            end
            JUMP: begin
                pc_src   = 2'd2;
                pc_write = 1'b1;
            end
`ifdef MIPS_JAL_EN
            JAL: begin
                reg_dst       = 2'd2;
                mem_to_reg    = 2'd2;
                reg_write_raw = 1'b1;
                pc_src        = 2'd2;
                pc_write      = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Strobes are also masked while reset is held so an aborted instruction commits nothing.
    assign go        = en & ~reset;
    assign ir_write  = go & ir_write_raw;
    assign mem_write = go & mem_write_raw;
    assign reg_write = go & reg_write_raw;
    assign pc_en     = go & (pc_write | (branch & zero));

endmodule
